kyber_byte_encoder: RTL

Streaming ByteEncode12 packer that sits on the output of the Kyber coefficient reduction pipeline. It accepts fully reduced 12-bit coefficients on an un-backpressured valid strobe and packs each even/odd pair into three bytes. Bytes are emitted on a valid/ready byte stream toward the ciphertext/key serializer. A small pair FIFO absorbs output stalls, and loss is flagged when the FIFO overflows.

---
 rtl/kyber_pkg.sv | 35 +++
 rtl/kyber_pair_fifo.sv | 65 ++++++
 rtl/kyber_byte_encoder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber types and constants for the ByteEncode12 output path.
// Also holds the byte-lane selection used by the serializer.
package kyber_pkg;

  localparam logic [11:0] KYBER_Q = 12'd3329;
  localparam int KYBER_N = 256;
  localparam int COEF_W = 12;

  typedef logic [COEF_W-1:0] coef_t;

  typedef struct packed {
    logic  last;
    coef_t c1;
    coef_t c0;
  } coef_pair_t;

  typedef enum logic [1:0] {
    PH_B0 = 2'd0,
    PH_B1 = 2'd1,
    PH_B2 = 2'd2
  } phase_e;

  // Three little-endian bytes carry the 24 bits of one coefficient pair
  function automatic logic [7:0] encode_byte(coef_pair_t pair, phase_e ph);
    logic [7:0] b;
    case (ph)
      PH_B0:   b = pair.c0[7:0];
      PH_B1:   b = {pair.c1[3:0], pair.c0[11:8]};
      PH_B2:   b = pair.c1[11:4];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/kyber_pair_fifo.sv
// Small synchronous FIFO of coefficient pairs; storage is not reset, pointers are.
// The caller only pushes when not full (or when popping) and only pops when not empty.
module kyber_pair_fifo
  import kyber_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  coef_pair_t wdata,
  output logic       full,
  output logic       empty,
  output coef_pair_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  coef_pair_t      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Pair storage
  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == '0);
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/kyber_byte_encoder.sv
// ByteEncode12 packer: pairs reduced coefficients, buffers pairs, and streams
// three bytes per pair on a valid/ready interface with polynomial framing.
module kyber_byte_encoder
  import kyber_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int N_COEFFS   = KYBER_N
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        coef_valid_i,
  input  logic [11:0] coef_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        last_o,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int CW = $clog2(N_COEFFS);
  localparam logic [CW-1:0] CIDX_LAST = CW'(N_COEFFS - 1);
  localparam logic [CW-1:0] CIDX_ONE  = CW'(1);

  logic [CW-1:0] cidx_r;
  coef_t         half_r;
  logic          half_pending_r;
  logic          overflow_r;
  phase_e        ph_r;

  logic          fifo_full_s;
  logic          fifo_empty_s;
  coef_pair_t    head_s;
  coef_pair_t    pair_s;
  logic          hs_s;
  logic          pop_s;
  logic          odd_s;
  logic          push_s;
  logic          drop_s;

  // clear_i wins over both a same-cycle handshake and a same-cycle coefficient
  assign hs_s   = !fifo_empty_s && byte_ready_i && !clear_i;
  assign pop_s  = hs_s && (ph_r == PH_B2);
  assign odd_s  = coef_valid_i && !clear_i && cidx_r[0];
  assign push_s = odd_s && (!fifo_full_s || pop_s);
  assign drop_s = odd_s && fifo_full_s && !pop_s;
  assign pair_s = {(cidx_r == CIDX_LAST), coef_i, half_r};

  kyber_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush  (clear_i),
    .push   (push_s),
    .pop    (pop_s),
    .wdata  (pair_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .head   (head_s)
  );

  // Coefficient index, half-pair register and sticky loss flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cidx_r         <= '0;
      half_r         <= '0;
      half_pending_r <= 1'b0;
      overflow_r     <= 1'b0;
    end else if (clear_i) begin
      cidx_r         <= '0;
      half_r         <= '0;
      half_pending_r <= 1'b0;
      overflow_r     <= 1'b0;
    end else begin
      if (coef_valid_i) begin
        cidx_r <= (cidx_r == CIDX_LAST) ? '0 : cidx_r + CIDX_ONE;
        if (!cidx_r[0]) begin
          half_r         <= coef_i;
          half_pending_r <= 1'b1;
        end else begin
          half_pending_r <= 1'b0;
        end
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Byte phase on the FIFO head; the third handshake retires the pair
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ph_r <= PH_B0;
    end else if (clear_i) begin
      ph_r <= PH_B0;
    end else if (hs_s) begin
      case (ph_r)
        PH_B0:   ph_r <= PH_B1;
        PH_B1:   ph_r <= PH_B2;
        PH_B2:   ph_r <= PH_B0;
        default: ph_r <= PH_B0;
      endcase
    end
  end

  // Output lanes are decoded purely from registered state, so they hold under stall
  always_comb begin
    byte_o = 8'd0;
    last_o = 1'b0;
    if (!fifo_empty_s) begin
      byte_o = encode_byte(head_s, ph_r);
      last_o = head_s.last && (ph_r == PH_B2);
    end else begin
      byte_o = 8'd0;
      last_o = 1'b0;
    end
  end

  assign byte_valid_o = !fifo_empty_s;
  assign overflow_o   = overflow_r;
  assign busy_o       = !fifo_empty_s || half_pending_r;

endmodule
